micro_uart_rx_fifo: RTL and testbench

//  Receive buffer between the micro UART receiver and the APB data register.

---
 rtl/micro_uart_rx_fifo.sv | 138 +++++++++++++
 tb/tb_micro_uart_rx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_uart_rx_fifo.sv
// Receive FIFO between the micro UART receiver and the APB data register.
// Optional idle-timeout interrupt is built only when MUA_RXFIFO_TIMEOUT_EN is defined.
module micro_uart_rx_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned TO_CYCLES = 240
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  input  logic          clr_ovf,
  output logic          has_data,
  output logic          full,
  output logic          overflow,
  output logic [AW:0]   level,
  output logic          timeout_irq
);

  localparam logic [1:0]  ST_EMPTY     = 2'd0;
  localparam logic [1:0]  ST_PART      = 2'd1;
  localparam logic [1:0]  ST_FULL      = 2'd2;
  localparam logic [AW:0] LP_DEPTH_LVL = (AW+1)'(DEPTH);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_level;
  logic [AW:0]   w_level_nxt;
  logic          r_overflow;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_ovf_set;
  logic [DW-1:0] r_mem [DEPTH];

  // Accept/drop decisions and next-state; a pop frees the slot a same-cycle push uses when full.
  always_comb begin
    w_pop_ok    = pop & (r_state != ST_EMPTY);
    w_push_ok   = push_valid & ((r_state != ST_FULL) | w_pop_ok);
    w_ovf_set   = push_valid & (r_state == ST_FULL) & ~w_pop_ok;
    w_level_nxt = r_level;
    w_state_nxt = r_state;
    if (w_push_ok & ~w_pop_ok) begin
      w_level_nxt = r_level + (AW+1)'(1);
    end else if (~w_push_ok & w_pop_ok) begin
      w_level_nxt = r_level - (AW+1)'(1);
    end
    case (r_state)
      ST_EMPTY: if (w_push_ok) w_state_nxt = ST_PART;
      ST_PART: begin
        if (w_level_nxt == LP_DEPTH_LVL) begin
          w_state_nxt = ST_FULL;
        end else if (w_level_nxt == '0) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: if (w_level_nxt != LP_DEPTH_LVL) w_state_nxt = ST_PART;
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = (r_state != ST_EMPTY) ? r_mem[r_rd_ptr] : '0;
  assign has_data = (r_state != ST_EMPTY);
  assign full     = (r_state == ST_FULL);
  assign overflow = r_overflow;
  assign level    = r_level;

`ifdef MUA_RXFIFO_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TO_CYCLES - 1);

  logic [15:0] r_idle_cnt;
  logic        r_timeout;
  logic        w_reload;

  assign w_reload = w_push_ok | w_pop_ok | (r_state == ST_EMPTY);

  // Idle counter saturates; the interrupt stays up until data is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_reload) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != 16'hFFFF) begin
        r_idle_cnt <= r_idle_cnt + 16'd1;
      end
      if (w_pop_ok) begin
        r_timeout <= 1'b0;
      end else if (!w_reload && (r_idle_cnt == LP_TO_LAST)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_irq = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = |32'(TO_CYCLES);
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_micro_uart_rx_fifo.sv
// Directed self-checking bench for micro_uart_rx_fifo (DEPTH=8, DW=8, TO_CYCLES=240).
module tb_micro_uart_rx_fifo;

  localparam int unsigned TO = 240;

  logic       clk;
  logic       reset_n;
  logic       push_valid;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       clr_ovf;
  logic       has_data;
  logic       full;
  logic       overflow;
  logic [3:0] level;
  logic       timeout_irq;

  int checks = 0;
  int errors = 0;

  micro_uart_rx_fifo #(.DEPTH(8), .AW(3), .DW(8), .TO_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .push_valid(push_valid), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .clr_ovf(clr_ovf), .has_data(has_data),
    .full(full), .overflow(overflow), .level(level), .timeout_irq(timeout_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic pv, input logic [7:0] pd, input logic pp, input logic co);
    push_valid = pv;
    push_data  = pd;
    pop        = pp;
    clr_ovf    = co;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop        = 1'b0;
    clr_ovf    = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (level !== 4'd0 || has_data !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 ||
        pop_data !== 8'h00 || timeout_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%0d has=%b full=%b ovf=%b data=%h to=%b, expected all zero",
               level, has_data, full, overflow, pop_data, timeout_irq);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_q [3];
    exp_q = '{8'h81, 8'h7E, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, exp_q[i], 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (level !== 4'd3 || has_data !== 1'b1) begin
      errors++;
      $display("FAIL basic_fill: level=%0d has=%b, expected 3/1", level, has_data);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      checks++;
      if (pop_data !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_pop%0d: got %h expected %h", i, pop_data, exp_q[i]);
      end
      tick();
    end
    checks++;
    if (has_data !== 1'b0 || pop_data !== 8'h00 || level !== 4'd0) begin
      errors++;
      $display("FAIL basic_drain: has=%b data=%h level=%0d, expected 0/00/0", has_data, pop_data, level);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill: full=%b level=%0d ovf=%b, expected 1/8/0", full, level, overflow);
    end
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    tick();
    checks++;
    if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: full=%b level=%0d ovf=%b, expected 1/8/1", full, level, overflow);
    end
    drive(1'b1, 8'hC3, 1'b0, 1'b1);
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_priority: ovf=%b expected 1", overflow);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      checks++;
      if (pop_data !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_pop%0d: got %h expected %h", i, pop_data, 8'(i));
      end
      tick();
    end
    checks++;
    if (overflow !== 1'b1 || level !== 4'd0) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b level=%0d, expected 1/0", overflow, level);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    #1;
    checks++;
    if (pop_data !== 8'h00) begin
      errors++;
      $display("FAIL full_pp_data: got %h expected 00", pop_data);
    end
    tick();
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_pp_state: level=%0d ovf=%b full=%b, expected 8/0/1", level, overflow, full);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      checks++;
      if (pop_data !== ((i == 8) ? 8'hAA : 8'(i))) begin
        errors++;
        $display("FAIL full_pp_pop%0d: got %h expected %h", i, pop_data, (i == 8) ? 8'hAA : 8'(i));
      end
      tick();
    end
  endtask

  task automatic test_empty_edges;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    checks++;
    if (pop_data !== 8'h00) begin
      errors++;
      $display("FAIL empty_pop_data: got %h expected 00", pop_data);
    end
    tick();
    checks++;
    if (level !== 4'd0 || has_data !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop_level: level=%0d has=%b, expected 0/0", level, has_data);
    end
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    #1;
    checks++;
    if (pop_data !== 8'h00) begin
      errors++;
      $display("FAIL empty_pp_data: got %h expected 00", pop_data);
    end
    tick();
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL empty_pp_level: got %0d expected 1", level);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    checks++;
    if (pop_data !== 8'h55) begin
      errors++;
      $display("FAIL empty_pp_pop: got %h expected 55", pop_data);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    int bad = 0;
    for (int n = 0; n < 20; n++) begin
      d = 8'(n * 17);
      drive(1'b1, d, 1'b0, 1'b0);
      tick();
      if (level !== 4'd1) bad++;
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      checks++;
      if (pop_data !== d) begin
        errors++;
        $display("FAIL wrap_pop%0d: got %h expected %h", n, pop_data, d);
      end
      tick();
      if (level !== 4'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_level: %0d level samples off, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (level !== 4'd5) begin
      errors++;
      $display("FAIL rst_mid_pre: level=%0d expected 5", level);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (level !== 4'd0 || has_data !== 1'b0 || pop_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_async: level=%0d has=%b data=%h, expected 0/0/00", level, has_data, pop_data);
    end
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout;
    int early = 0;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
`ifdef MUA_RXFIFO_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      tick();
      if (timeout_irq !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: irq high on %0d cycles, expected 0", early);
    end
    tick();
    checks++;
    if (timeout_irq !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: irq=%b expected 1", timeout_irq);
    end
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (timeout_irq !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: irq=%b expected 1", timeout_irq);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checks++;
    if (timeout_irq !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: irq=%b expected 0", timeout_irq);
    end
`else
    for (int k = 0; k < TO + 20; k++) begin
      tick();
      if (timeout_irq !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_disabled: irq high on %0d cycles, expected 0", early);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
`endif
    checks++;
    if (level !== 4'd0) begin
      errors++;
      $display("FAIL timeout_drain: level=%0d expected 0", level);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    push_valid = 1'b0;
    push_data  = 8'h00;
    pop        = 1'b0;
    clr_ovf    = 1'b0;
    #12;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_edges();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
